// File: rtl/sc_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sc_mac_pkg
// Description : Shared FSM state encoding and default widths for sc_mac_accum.
// Revision    : 1.0 - initial release
// ============================================================================
package sc_mac_pkg;

    localparam int C_ACC_W_DEF = 16;
    localparam int C_NT_W_DEF  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sat_acc.sv
`default_nettype none
// ============================================================================
// Module      : sat_acc
// Description : Signed saturating +/-1 accumulator with clear and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_acc #(
    parameter int ACC_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clr,
    input  logic                    i_en,
    input  logic                    i_neg,
    output logic signed [ACC_W-1:0] o_acc,
    output logic                    o_ovf
);

    localparam logic signed [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] C_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_ovf;

    // A clipped step leaves the value pinned and latches the overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_en) begin
            if (i_neg) begin
                if (r_acc == C_MIN) r_ovf <= 1'b1;
                else                r_acc <= r_acc - C_ONE;
            end else begin
                if (r_acc == C_MAX) r_ovf <= 1'b1;
                else                r_acc <= r_acc + C_ONE;
            end
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule
`default_nettype wire

// File: rtl/sc_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : sc_mac_accum
// Description : Stochastic-computing dot-product sequencer driving an external
//               down counter and a saturating +/-1 accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module sc_mac_accum
    import sc_mac_pkg::*;
#(
    parameter int ACC_W = C_ACC_W_DEF,
    parameter int NT_W  = C_NT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NT_W-1:0]         n_terms,
    input  logic                    term_valid,
    input  logic                    term_neg,
    output logic                    term_ready,
    output logic                    cnt_load,
    input  logic                    cnt_stop,
    input  logic                    sbit,
    output logic signed [ACC_W-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic                    ovf
);

    state_t          r_state;
    logic [NT_W-1:0] r_n_terms;
    logic [NT_W:0]   r_idx;
    logic            r_neg;
    logic            r_term_ready;
    logic            r_result_valid;

    logic            w_hs;
    logic            w_acc_clr;
    logic            w_acc_en;
    logic [NT_W:0]   w_idx_next;

    // r_term_ready is high exactly while in LOAD, so it doubles as the state qualifier
    assign w_hs       = r_term_ready & term_valid;
    assign w_acc_clr  = (r_state == ST_IDLE) & start;
    assign w_acc_en   = (r_state == ST_RUN) & ~cnt_stop & sbit;
    assign w_idx_next = r_idx + {{NT_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_n_terms      <= '0;
            r_idx          <= '0;
            r_neg          <= 1'b0;
            r_term_ready   <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_n_terms <= n_terms;
                        r_idx     <= '0;
                        if (n_terms == '0) begin
                            r_state        <= ST_DONE;
                            r_result_valid <= 1'b1;
                        end else begin
                            r_state      <= ST_LOAD;
                            r_term_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (term_valid) begin
                        r_neg        <= term_neg;
                        r_term_ready <= 1'b0;
                        r_state      <= ST_ARM;
                    end
                end
                // Gives the external counter a cycle to settle after its load
                ST_ARM: r_state <= ST_RUN;
                ST_RUN: begin
                    if (cnt_stop) begin
                        r_idx <= w_idx_next;
                        if (w_idx_next < {1'b0, r_n_terms}) begin
                            r_state      <= ST_LOAD;
                            r_term_ready <= 1'b1;
                        end else begin
                            r_state        <= ST_DONE;
                            r_result_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        r_state        <= ST_IDLE;
                        r_result_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_term_ready   <= 1'b0;
                    r_result_valid <= 1'b0;
                end
            endcase
        end
    end

    sat_acc #(
        .ACC_W (ACC_W)
    ) u_sat_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_acc_clr),
        .i_en  (w_acc_en),
        .i_neg (r_neg),
        .o_acc (result),
        .o_ovf (ovf)
    );

    assign term_ready   = r_term_ready;
    assign cnt_load     = w_hs;
    assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_sc_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_sc_mac_accum
// Description : Randomized bench for sc_mac_accum (16-bit and 4-bit instances)
//               against a saturating dot-product reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_mac_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  n_terms = '0;
    logic        term_valid = 1'b0;
    logic        term_neg = 1'b0;
    logic        sbit = 1'b0;
    logic        result_ready = 1'b0;
    logic        cnt_stop;

    logic               tr16, cl16, rv16, ovf16;
    logic signed [15:0] res16;
    logic               tr4, cl4, rv4, ovf4;
    logic signed [3:0]  res4;

    int checks = 0;
    int errors = 0;

    // Stimulus tables for the current dot product
    int          ws   [16];
    bit          negs [16];
    logic [15:0] pats [16];

    // External down-counter model
    logic [3:0]  term_w = '0, cnt = '0, cur_w = '0;
    logic [15:0] term_pat = '0, cur_pat = '0;
    logic        hold = 1'b0;
    int          load_count = 0;
    bit          tr_seen = 1'b0;

    always #5 clk = ~clk;

    sc_mac_accum #(.ACC_W(16), .NT_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
        .term_valid(term_valid), .term_neg(term_neg), .term_ready(tr16),
        .cnt_load(cl16), .cnt_stop(cnt_stop), .sbit(sbit), .result(res16),
        .result_valid(rv16), .result_ready(result_ready), .ovf(ovf16)
    );

    sc_mac_accum #(.ACC_W(4), .NT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .n_terms(n_terms),
        .term_valid(term_valid), .term_neg(term_neg), .term_ready(tr4),
        .cnt_load(cl4), .cnt_stop(cnt_stop), .sbit(sbit), .result(res4),
        .result_valid(rv4), .result_ready(result_ready), .ovf(ovf4)
    );

    assign cnt_stop = (cnt == 4'd0);

    always @(posedge clk) begin
        if (cl16) begin
            cnt     <= term_w;
            cur_w   <= term_w;
            cur_pat <= term_pat;
            hold    <= 1'b1;
        end else if (hold) begin
            hold <= 1'b0;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
        if (cl16) load_count <= load_count + 1;
        if (tr16) tr_seen <= 1'b1;
    end

    task automatic check_val(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Each set pattern bit is one +/-1 step, clipped at the signed range of acc_w
    function automatic void ref_dot(input int n, input int acc_w,
                                    output longint res, output bit ov);
        longint mx, mn, step;
        mx = (longint'(1) <<< (acc_w - 1)) - 1;
        mn = -mx - 1;
        res = 0;
        ov  = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < ws[k]; b++) begin
                if (pats[k][b]) begin
                    step = negs[k] ? -1 : 1;
                    if (res + step > mx || res + step < mn) ov = 1'b1;
                    else res = res + step;
                end
            end
        end
    endfunction

    task automatic fill_rand(input int n);
        for (int k = 0; k < 16; k++) begin
            ws[k]   = (k < n) ? int'($urandom_range(0, 15)) : 0;
            negs[k] = 1'($urandom);
            pats[k] = 16'($urandom);
        end
    endtask

    task automatic run_dot(input int n, input bit hold_valid, input bit noise_start,
                           input bit do_reset);
        longint e16, e4;
        bit     o16, o4;
        int     exp_lat, cycles, k, stall;
        logic signed [15:0] held;
        ref_dot(n, 16, e16, o16);
        ref_dot(n, 4, e4, o4);
        exp_lat = 0;
        for (int i = 0; i < n; i++) exp_lat += 3 + ws[i];
        load_count = 0;
        tr_seen    = 1'b0;
        start   = 1'b1;
        n_terms = 4'(n);
        @(negedge clk);
        start  = 1'b0;
        k      = 0;
        cycles = 0;
        while (!rv16 && cycles < 1000) begin
            if (tr16 && k < n) begin
                term_valid = 1'b1;
                term_w     = 4'(ws[k]);
                term_neg   = negs[k];
                term_pat   = pats[k];
                k++;
            end else begin
                term_valid = hold_valid;
                term_w     = 4'($urandom);
                term_neg   = 1'($urandom);
                term_pat   = 16'($urandom);
            end
            start = noise_start ? 1'($urandom) : 1'b0;
            sbit  = (cnt != 4'd0) ? cur_pat[cur_w - cnt] : 1'($urandom);
            if (do_reset && k == 2 && !tr16 && !hold && cnt != 4'd0) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_result16", res16, 0);
                check_val("rst_result4", res4, 0);
                check_val("rst_valid", rv16, 0);
                check_val("rst_ready", tr16, 0);
                check_val("rst_cnt_load", cl16, 0);
                check_val("rst_ovf", ovf16, 0);
                @(negedge clk);
                term_valid = 1'b0;
                start      = 1'b0;
                rst_n      = 1'b1;
                @(negedge clk);
                check_val("post_rst_valid", rv16, 0);
                check_val("post_rst_ready", tr16, 0);
                return;
            end
            @(negedge clk);
            cycles++;
        end
        term_valid = 1'b0;
        start      = 1'b0;
        check_val("latency", cycles, exp_lat);
        check_val("result16", res16, e16);
        check_val("ovf16", ovf16, o16);
        check_val("result4", res4, e4);
        check_val("ovf4", ovf4, o4);
        check_val("valid4", rv4, 1);
        check_val("loads", load_count, n);
        if (n == 0) check_val("ready_never", tr_seen, 0);
        held  = res16;
        stall = $urandom_range(0, 3);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check_val("hold_valid", rv16, 1);
            check_val("hold_result", res16, held);
        end
        result_ready = 1'b1;
        start        = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        start        = 1'b0;
        check_val("drop_valid", rv16, 0);
        check_val("no_restart", tr16, 0);
        @(negedge clk);
        check_val("idle_ready", tr16, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_result", res16, 0);
        check_val("reset_valid", rv16, 0);
        check_val("reset_ready", tr16, 0);
        check_val("reset_ovf", ovf16, 0);
        rst_n = 1'b1;
        @(negedge clk);

        fill_rand(0);
        ws[0] = 5; negs[0] = 1'b0; pats[0] = 16'hFFFF;
        run_dot(1, 1'b0, 1'b0, 1'b0);
        check_val("t038_value", res16, 5);

        fill_rand(0);
        ws[0] = 4; ws[1] = 0; ws[2] = 2;
        negs[0] = 1'b0; negs[1] = 1'b0; negs[2] = 1'b1;
        pats[0] = 16'hFFFF; pats[1] = 16'hFFFF; pats[2] = 16'hFFFF;
        run_dot(3, 1'b0, 1'b0, 1'b0);
        check_val("t039_value", res16, 2);

        fill_rand(0);
        run_dot(0, 1'b0, 1'b0, 1'b0);

        fill_rand(0);
        ws[0] = 7; ws[1] = 7; negs[0] = 1'b0; negs[1] = 1'b0;
        pats[0] = 16'hFFFF; pats[1] = 16'hFFFF;
        run_dot(2, 1'b0, 1'b0, 1'b0);
        check_val("t041_res4", res4, 7);
        check_val("t041_ovf4", ovf4, 1);

        fill_rand(3);
        ws[1] = 4; pats[1] = 16'hFFFF;
        run_dot(3, 1'b0, 1'b0, 1'b1);
        fill_rand(0);
        ws[0] = 3; negs[0] = 1'b0; pats[0] = 16'hFFFF;
        run_dot(1, 1'b0, 1'b0, 1'b0);
        check_val("t042_value", res16, 3);

        fill_rand(4);
        run_dot(4, 1'b1, 1'b1, 1'b0);

        fill_rand(15);
        run_dot(15, 1'b0, 1'b0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            int n;
            n = $urandom_range(0, 15);
            fill_rand(n);
            run_dot(n, 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sc_mac_accum.md
SC_MAC_ACCUM -- requirements
Module: sc_mac_accum

Interface
REQ-001 Parameter ACC_W, default 16: signed accumulator/result width in bits.
REQ-002 Parameter NT_W, default 4: width of the term-count input.
REQ-003 clk  in  1  single clock; all state SHALL update on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a new dot product; sampled only in IDLE.
REQ-006 n_terms  in  NT_W  number of product terms; captured with start.
REQ-007 term_valid  in  1  upstream presents the next term (weight loaded into the down counter, activation bitstream armed).
REQ-008 term_neg  in  1  sign of the current term; captured on term handshake.
REQ-009 term_ready  out  1  block accepts a term; high only in LOAD.
REQ-010 cnt_load  out  1  one-cycle pulse driving the down counter's load/reset input.
REQ-011 cnt_stop  in  1  down counter's STOP flag, high once its count reaches zero.
REQ-012 sbit  in  1  stochastic activation bit for the current cycle.
REQ-013 result  out  ACC_W  signed dot-product result.
REQ-014 result_valid  out  1  result is held and valid.
REQ-015 result_ready  in  1  downstream accepts the result.
REQ-016 ovf  out  1  sticky saturation flag for the current result.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, ARM, RUN, DONE.
REQ-018 IDLE: on start=1, capture n_terms, clear accumulator, term index and ovf; go LOAD, or go DONE if n_terms==0.
REQ-019 LOAD: assert term_ready; on term_valid&term_ready, capture term_neg, pulse cnt_load for exactly that cycle, go ARM.
REQ-020 ARM: one cycle; cnt_stop and sbit ignored (covers counter clear after load); go RUN.
REQ-021 RUN, cnt_stop==0: if sbit==1, add +1, or -1 when term_neg=1; if sbit==0, accumulator unchanged.
REQ-022 RUN, cnt_stop==1: sbit of that cycle not accumulated; term ends; go LOAD if index+1 < n_terms, else DONE; increment index.
REQ-023 Net effect: each term contributes ±(count of sbit ones over the cycles before stop), i.e. ±w·p.
REQ-024 Weight 0: cnt_stop already high in first RUN cycle; term contributes 0 and occupies LOAD+ARM+1 cycles.
REQ-025 Accumulator SHALL saturate at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)); any clipped update sets ovf, which holds until the next start.
REQ-026 DONE: result_valid=1, result and ovf stable; on result_ready=1 go IDLE, result_valid low next cycle.
REQ-027 start outside IDLE SHALL be ignored; no queuing.
REQ-028 term_valid outside LOAD SHALL be ignored; cnt_load never asserts outside LOAD.
REQ-029 start and result_ready in the same DONE cycle: only result_ready acts; start is not sampled.
REQ-030 result SHALL equal the accumulator at all times; only result_valid qualifies it.
REQ-031 Term index SHALL be NT_W+1 bits wide so n_terms = 2^NT_W-1 completes without wrap.

Reset
REQ-032 rst_n low SHALL force IDLE, accumulator=0, index=0, ovf=0, term_ready=0, cnt_load=0, result_valid=0, asynchronously.
REQ-033 Reset mid-RUN or mid-DONE SHALL discard partial or held results; no pulse on any output at deassertion.
REQ-034 rst_n deassertion is synchronous to clk by system design; the block needs no internal synchronizer.

Structure
REQ-035 Package sc_mac_pkg SHALL hold the FSM state enum and default ACC_W/NT_W constants.
REQ-036 One sub-module, sat_acc: ACC_W signed saturating ±1 accumulator with clear, enable, sign and overflow outputs.
REQ-037 The down counter is external; this block only drives cnt_load and reads cnt_stop.

Verification
REQ-038 n_terms=1, w=5, sbit=1 every cycle, term_neg=0 -> result=+5, ovf=0, result_valid until result_ready.
REQ-039 n_terms=3, weights 4,0,2, sbit all ones, signs +,+,- -> result=+2; weight-0 term spans 3 cycles and adds 0.
REQ-040 n_terms=0 with start -> DONE next cycle, result=0, term_ready never asserted.
REQ-041 ACC_W=4, n_terms=2, w=7 each, sbit all ones, positive -> result=+7, ovf=1; the next start clears ovf.
REQ-042 rst_n low during RUN of term 2 -> all outputs at reset values immediately; a fresh 1-term w=3 run yields 3.
REQ-043 start pulsed during RUN, and term_valid held in RUN -> no effect; cnt_load pulses exactly n_terms times per dot product.
